// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART receiver frame constants and receive FSM state type
// Optional build macro: UART_RX_PARITY_EN adds the RX_PARITY state.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    , RX_PARITY = 3'd4
`endif
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial input line
// Ports:
//   clk   - receiver clock
//   rst_n - synchronous active-low reset, both flops reset to idle-high
//   din   - asynchronous serial line
//   dout  - synchronized line value
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with one-entry valid/ready output buffer
// Optional build macro: UART_RX_PARITY_EN (even parity bit, parity_error output).
// Ports:
//   clk          - single clock, rising edge
//   rst_n        - synchronous active-low reset
//   pin_rx       - asynchronous serial line, idle high, LSB first
//   pin_rts      - flow control, 0 = may send, 1 = hold (buffer full)
//   data         - received byte, meaningful while valid is 1
//   valid        - output buffer holds an unconsumed byte
//   ready        - consumer accept; transfer when valid and ready
//   frame_error  - one-cycle pulse when the stop bit is sampled low
//   overrun      - one-cycle pulse when a completed byte is dropped
//   parity_error - one-cycle pulse on parity mismatch (UART_RX_PARITY_EN only)
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 30000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pin_rx,
  output logic                 pin_rts,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_error,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_error
`endif
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  // Half a bit from the falling edge lands the first sample mid start bit.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = RX_PARITY;
`else
  localparam rx_state_t AFTER_DATA = RX_STOP;
`endif

  logic                 rx_s;
  rx_state_t            state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [BIT_W-1:0]     bit_idx, bit_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic                 stop_hold, stop_hold_d;
  logic                 byte_done, byte_done_d;
  logic                 frame_error_d;
  logic                 valid_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                 drop, drop_d;
  logic                 parity_error_d;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (pin_rx),
    .dout  (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RX_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      stop_hold   <= 1'b0;
      byte_done   <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      drop         <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      bit_idx     <= bit_d;
      shift       <= shift_d;
      stop_hold   <= stop_hold_d;
      byte_done   <= byte_done_d;
      frame_error <= frame_error_d;
`ifdef UART_RX_PARITY_EN
      drop         <= drop_d;
      parity_error <= parity_error_d;
`endif
    end
  end

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    bit_d         = bit_idx;
    shift_d       = shift;
    stop_hold_d   = stop_hold;
    byte_done_d   = 1'b0;
    frame_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    drop_d         = drop;
    parity_error_d = 1'b0;
`endif
    case (state)
      RX_IDLE: begin
        stop_hold_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        drop_d = 1'b0;
`endif
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else if (!rx_s) begin
          state_d = RX_DATA;
          cnt_d   = FULL_LOAD;
          bit_d   = '0;
        end else begin
          state_d = RX_IDLE;  // line went back high: a glitch, not a start bit
        end
      end
      RX_DATA: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          shift_d[bit_idx] = rx_s;
          cnt_d            = FULL_LOAD;
          if (bit_idx == LAST_BIT) begin
            state_d = AFTER_DATA;
          end else begin
            bit_d = bit_idx + BIT_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          // Even parity: data bits plus parity bit carry an even count of ones.
          if (rx_s != ^shift) begin
            parity_error_d = 1'b1;
            drop_d         = 1'b1;
          end
          state_d = RX_STOP;
          cnt_d   = FULL_LOAD;
        end
      end
`endif
      RX_STOP: begin
        if (stop_hold) begin
          // Broken frame: wait for the line to return high before re-arming.
          if (rx_s) state_d = RX_IDLE;
        end else if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else if (rx_s) begin
          state_d = RX_IDLE;
`ifdef UART_RX_PARITY_EN
          byte_done_d = !drop;
`else
          byte_done_d = 1'b1;
`endif
        end else begin
          frame_error_d = 1'b1;
          stop_hold_d   = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // One-entry output buffer. A completion coinciding with a transfer refills
  // the slot; a completion into a full, non-accepting slot is dropped.
  always_comb begin
    valid_d   = valid;
    data_d    = data;
    overrun_d = 1'b0;
    if (byte_done) begin
      if (!valid || ready) begin
        valid_d = 1'b1;
        data_d  = shift;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      data    <= '0;
      overrun <= 1'b0;
      pin_rts <= 1'b1;
    end else begin
      valid   <= valid_d;
      data    <= data_d;
      overrun <= overrun_d;
      pin_rts <= valid_d;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CLK_FREQ_HZ = 30000000;
  localparam int BAUD_RATE   = 115200;
  localparam int CLKS        = CLK_FREQ_HZ / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Cycles from driving the start edge to the visible completion:
  // 2 sync stages, 1 to leave idle, half a bit to the start centre,
  // 9 (+parity) whole bits to the stop centre, 1 to publish the byte.
  localparam int DONE_LAT = 2 + 1 + CLKS / 2 + (9 + PB) * CLKS + 1;
  localparam int STOP_LAT = DONE_LAT - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pin_rx = 1'b1;
  logic       ready = 1'b0;
  logic       pin_rts;
  logic [7:0] data;
  logic       valid;
  logic       frame_error;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  uart_receiver #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pin_rx      (pin_rx),
    .pin_rts     (pin_rts),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .frame_error (frame_error),
    .overrun     (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_error(parity_error)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation side: record what the consumer sees, sampled at negedge.
  logic [7:0] got_q[$];
  int         rise_q[$];
  int         ferr_cnt, ferr_cyc, ovr_cnt, ovr_cyc, perr_cnt, rts_bad;
  logic       valid_prev = 1'b0;

  always @(negedge clk) begin
    if (valid && ready) got_q.push_back(data);
    if (valid && !valid_prev) rise_q.push_back(cyc);
    valid_prev = valid;
    if (frame_error) begin ferr_cnt++; ferr_cyc = cyc; end
    if (overrun) begin ovr_cnt++; ovr_cyc = cyc; end
`ifdef UART_RX_PARITY_EN
    if (parity_error) perr_cnt++;
`endif
    if (rst_n && pin_rts !== valid) rts_bad++;
  end

  task automatic clear_mon();
    got_q.delete();
    rise_q.delete();
    ferr_cnt = 0; ferr_cyc = -1; ovr_cnt = 0; ovr_cyc = -1; perr_cnt = 0; rts_bad = 0;
  endtask

  // Advance n clocks and park 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val, input logic par_flip, input int gap);
    pin_rx = 1'b0;
    step(CLKS);
    for (int i = 0; i < 8; i++) begin
      pin_rx = b[i];
      step(CLKS);
    end
    if (PB == 1) begin
      pin_rx = (^b) ^ par_flip;
      step(CLKS);
    end
    pin_rx = stop_val;
    step(CLKS);
    pin_rx = 1'b1;
    step(gap);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pin_rx = 1'b0; ready = 1'b0;
    step(4);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL reset_frame_error got=%0b exp=0", frame_error); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    checks++; if (pin_rts !== 1'b1) begin failures++; $display("FAIL reset_pin_rts got=%0b exp=1", pin_rts); end
    checks++; if (dut.rx_s !== 1'b1) begin failures++; $display("FAIL reset_sync got=%0b exp=1", dut.rx_s); end
    checks++; if (dut.state !== RX_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, RX_IDLE); end
    pin_rx = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(4);
    checks++; if (pin_rts !== 1'b0) begin failures++; $display("FAIL release_pin_rts got=%0b exp=0", pin_rts); end
  endtask

  task automatic test_basic();
    int f;
    clear_mon(); ready = 1'b1; f = cyc;
    send_frame(8'h45, 1'b1, 1'b0, 40);
    checks++; if (rise_q.size() !== 1) begin failures++; $display("FAIL basic_rises got=%0d exp=1", rise_q.size()); end
    checks++; if ((rise_q.size() > 0 ? rise_q[0] : -1) !== f + DONE_LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", (rise_q.size() > 0 ? rise_q[0] : -1), f + DONE_LAT); end
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL basic_count got=%0d exp=1", got_q.size()); end
    checks++; if ((got_q.size() > 0 ? got_q[0] : 8'hxx) !== 8'h45) begin failures++; $display("FAIL basic_data got=%h exp=45", (got_q.size() > 0 ? got_q[0] : 8'hxx)); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL basic_valid_after got=%0b exp=0", valid); end
    checks++; if (ferr_cnt + ovr_cnt !== 0) begin failures++; $display("FAIL basic_errors got=%0d exp=0", ferr_cnt + ovr_cnt); end
  endtask

  task automatic test_glitch();
    clear_mon(); ready = 1'b1;
    pin_rx = 1'b0; step(100);
    pin_rx = 1'b1; step(400);
    checks++; if (rise_q.size() !== 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", rise_q.size()); end
    checks++; if (ferr_cnt !== 0) begin failures++; $display("FAIL glitch_frame_error got=%0d exp=0", ferr_cnt); end
    checks++; if (dut.state !== RX_IDLE) begin failures++; $display("FAIL glitch_state got=%0d exp=%0d", dut.state, RX_IDLE); end
  endtask

  task automatic test_frame_error();
    int f;
    clear_mon(); ready = 1'b1; f = cyc;
    send_frame(8'hA5, 1'b0, 1'b0, 20);
    checks++; if (ferr_cnt !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt); end
    checks++; if (ferr_cyc !== f + STOP_LAT) begin failures++; $display("FAIL ferr_cycle got=%0d exp=%0d", ferr_cyc, f + STOP_LAT); end
    checks++; if (rise_q.size() !== 0) begin failures++; $display("FAIL ferr_valid got=%0d exp=0", rise_q.size()); end
    send_frame(8'h3C, 1'b1, 1'b0, 40);
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL ferr_next_count got=%0d exp=1", got_q.size()); end
    checks++; if ((got_q.size() > 0 ? got_q[0] : 8'hxx) !== 8'h3C) begin failures++; $display("FAIL ferr_next_data got=%h exp=3c", (got_q.size() > 0 ? got_q[0] : 8'hxx)); end
  endtask

  task automatic test_overrun();
    int f;
    clear_mon(); ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 40);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL ovr_first_valid got=%0b exp=1", valid); end
    checks++; if (data !== 8'h11) begin failures++; $display("FAIL ovr_first_data got=%h exp=11", data); end
    checks++; if (pin_rts !== 1'b1) begin failures++; $display("FAIL ovr_pin_rts got=%0b exp=1", pin_rts); end
    f = cyc;
    send_frame(8'h22, 1'b1, 1'b0, 40);
    checks++; if (ovr_cnt !== 1) begin failures++; $display("FAIL ovr_count got=%0d exp=1", ovr_cnt); end
    checks++; if (ovr_cyc !== f + DONE_LAT) begin failures++; $display("FAIL ovr_cycle got=%0d exp=%0d", ovr_cyc, f + DONE_LAT); end
    checks++; if (data !== 8'h11 || valid !== 1'b1) begin failures++; $display("FAIL ovr_held got=%h/%0b exp=11/1", data, valid); end
    ready = 1'b1; step(2); ready = 1'b0;
    checks++; if (got_q.size() !== 1 || (got_q.size() > 0 ? got_q[0] : 8'hxx) !== 8'h11) begin failures++; $display("FAIL ovr_drain got=%0d items exp=1 item 11", got_q.size()); end
    checks++; if (valid !== 1'b0 || pin_rts !== 1'b0) begin failures++; $display("FAIL ovr_empty got=%0b/%0b exp=0/0", valid, pin_rts); end
  endtask

  task automatic test_simultaneous();
    int f;
    clear_mon(); ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 40);
    f = cyc;
    fork
      send_frame(8'h22, 1'b1, 1'b0, 40);
      begin
        step(DONE_LAT - 1);  // ready is high for exactly the completion edge
        ready = 1'b1;
        step(1);
        ready = 1'b0;
      end
    join
    checks++; if (ovr_cnt !== 0) begin failures++; $display("FAIL sim_overrun got=%0d exp=0", ovr_cnt); end
    checks++; if (valid !== 1'b1 || data !== 8'h22) begin failures++; $display("FAIL sim_loaded got=%0b/%h exp=1/22", valid, data); end
    checks++; if (got_q.size() !== 1 || (got_q.size() > 0 ? got_q[0] : 8'hxx) !== 8'h11) begin failures++; $display("FAIL sim_transfer got=%0d items exp=1 item 11", got_q.size()); end
    checks++; if (rise_q.size() !== 1) begin failures++; $display("FAIL sim_valid_stays got=%0d rises exp=1", rise_q.size()); end
    ready = 1'b1; step(2); ready = 1'b0;
    checks++; if (got_q.size() !== 2 || (got_q.size() > 1 ? got_q[1] : 8'hxx) !== 8'h22) begin failures++; $display("FAIL sim_drain got=%0d items exp=2 items", got_q.size()); end
  endtask

  task automatic test_reset_midframe();
    clear_mon(); ready = 1'b1;
    fork
      send_frame(8'hFF, 1'b1, 1'b0, 40);
      begin
        step(5 * CLKS + 40);  // inside data bit 4
        rst_n = 1'b0;
        step(3);
        checks++; if (valid !== 1'b0 || data !== 8'h00) begin failures++; $display("FAIL mid_reset_out got=%0b/%h exp=0/00", valid, data); end
        checks++; if (pin_rts !== 1'b1 || frame_error !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL mid_reset_flags got=%0b%0b%0b exp=100", pin_rts, frame_error, overrun); end
        checks++; if (dut.state !== RX_IDLE) begin failures++; $display("FAIL mid_reset_state got=%0d exp=%0d", dut.state, RX_IDLE); end
        rst_n = 1'b1;
      end
    join
    checks++; if (rise_q.size() !== 0) begin failures++; $display("FAIL mid_abandon got=%0d rises exp=0", rise_q.size()); end
    clear_mon();
    send_frame(8'h5A, 1'b1, 1'b0, 40);
    checks++; if (got_q.size() !== 1 || (got_q.size() > 0 ? got_q[0] : 8'hxx) !== 8'h5A) begin failures++; $display("FAIL mid_next got=%0d items exp=1 item 5a", got_q.size()); end
`ifdef UART_RX_PARITY_EN
    clear_mon();
    send_frame(8'h5A, 1'b1, 1'b1, 40);
    checks++; if (perr_cnt !== 1) begin failures++; $display("FAIL parity_pulse got=%0d exp=1", perr_cnt); end
    checks++; if (rise_q.size() !== 0) begin failures++; $display("FAIL parity_discard got=%0d rises exp=0", rise_q.size()); end
`endif
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic       bad;
    int         nbad = 0;
    clear_mon(); ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      send_frame(b, !bad, 1'b0, $urandom_range(2, 30));
      if (bad) nbad++;
      else exp_q.push_back(b);
    end
    step(20);
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (ferr_cnt !== nbad) begin failures++; $display("FAIL rand_frame_errors got=%0d exp=%0d", ferr_cnt, nbad); end
    checks++; if (ovr_cnt !== 0) begin failures++; $display("FAIL rand_overrun got=%0d exp=0", ovr_cnt); end
    checks++; if (rts_bad !== 0) begin failures++; $display("FAIL rand_rts_tracks_valid got=%0d exp=0", rts_bad); end
  endtask

  initial begin
    clear_mon();
    step(1);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_simultaneous();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 30000000, SHALL set the clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, SHALL set the line rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer division, 260 at defaults).
REQ-003 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  SHALL be a synchronous, active-low reset.
REQ-005 pin_rx  input  1  SHALL be the asynchronous serial line: idle high, 8N1, LSB first.
REQ-006 pin_rts  output  1  SHALL be active-low flow control: 0 = may send, 1 = hold.
REQ-007 data  output  8  SHALL carry the received byte while valid is 1.
REQ-008 valid  output  1  SHALL flag that data holds an unconsumed byte.
REQ-009 ready  input  1  SHALL be the consumer accept; a transfer occurs when valid and ready are both 1 on a clock edge.
REQ-010 frame_error  output  1  SHALL pulse for one cycle when a stop bit is sampled low.
REQ-011 overrun  output  1  SHALL pulse for one cycle when a completed byte is dropped.

Function
REQ-012 pin_rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rx_s.
REQ-013 States SHALL be IDLE, START, DATA, STOP, plus PARITY when UART_RX_PARITY_EN is defined.
REQ-014 IDLE: rx_s == 0 SHALL enter START and load the bit counter with CLKS_PER_BIT/2 - 1.
REQ-015 START: at count expiry, rx_s == 0 SHALL enter DATA; rx_s == 1 SHALL return to IDLE as a glitch, with no output.
REQ-016 DATA: rx_s SHALL be sampled every CLKS_PER_BIT cycles into bit index 0..7, LSB first; after bit 7 the FSM SHALL advance.
REQ-017 STOP: at the sample point, rx_s == 1 SHALL complete the byte; rx_s == 0 SHALL pulse frame_error, discard the byte, and hold in STOP until rx_s == 1, then enter IDLE.
REQ-018 Byte completion SHALL assert valid and update data on the cycle after the stop-bit sample.
REQ-019 The output holding register is one entry: valid SHALL stay 1 and data SHALL stay stable until a transfer.
REQ-020 If a byte completes while valid == 1 and ready == 0, the new byte SHALL be dropped, the held byte kept, and overrun pulsed.
REQ-021 If a byte completes in the same cycle as a transfer, the new byte SHALL be loaded, valid SHALL stay 1, and overrun SHALL NOT pulse.
REQ-022 pin_rts SHALL equal valid, registered: high while the buffer is full.
REQ-023 Bit and cycle counters SHALL be sized with $clog2 of their maxima and SHALL NOT wrap in normal operation.

Reset
REQ-024 While rst_n == 0 the FSM SHALL be in IDLE, synchronizer flops 1, data 0, valid 0, frame_error 0, overrun 0, and pin_rts 1.
REQ-025 Reset mid-frame SHALL abandon the frame; after release the FSM SHALL wait in IDLE for the next falling edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN, when defined, SHALL add an even-parity bit sampled in PARITY between DATA and STOP, and an output parity_error (1 bit) pulsed on mismatch.
REQ-027 On a parity mismatch the byte SHALL be discarded.
REQ-028 When UART_RX_PARITY_EN is undefined, the PARITY state and the parity_error port SHALL be absent and the frame is 8N1.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state enum (rx_state_t) and the frame constants DATA_BITS = 8 and STOP_BITS = 1.
REQ-030 Sub-module uart_rx_sync SHALL implement the 2-flop synchronizer with reset value 1.

Verification
REQ-031 At defaults (260 clk/bit), send 0x45 with ready = 1 -> valid pulses with data = 0x45, and the valid rising edge falls 1 cycle after the stop sample.
REQ-032 Drive a 100-cycle low glitch on pin_rx -> no valid, no frame_error, FSM back in IDLE.
REQ-033 Send 0xA5 with the stop bit forced low -> frame_error pulses once, valid stays 0, and a following 0x3C is received correctly.
REQ-034 Hold ready = 0 and send 0x11 then 0x22 -> data = 0x11 held, pin_rts = 1 after the first byte, and overrun pulses once at the second stop.
REQ-035 Set ready = 1 exactly on the completion cycle of byte 0x22 with 0x11 held -> 0x11 transferred, data = 0x22, valid stays 1, no overrun.
REQ-036 Assert rst_n = 0 during bit 4 of 0xFF, then send 0x5A -> outputs reset per REQ-024, then 0x5A received correctly (with UART_RX_PARITY_EN, parity bit 0; flipped to 1 -> parity_error pulses).
